// File: rtl/airi5c_pcpi_issue_pkg.sv
// Shared constants for the PCPI issue block: FSM state encodings, default timeout, and the NOP word.
package airi5c_pcpi_issue_pkg;

  typedef enum logic [1:0] {
    PCPI_ST_IDLE  = 2'd0,
    PCPI_ST_ISSUE = 2'd1,
    PCPI_ST_DONE  = 2'd2,
    PCPI_ST_ERR   = 2'd3
  } pcpi_state_e;

  localparam int unsigned PCPI_TIMEOUT_DEFAULT = 16;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/airi5c_pcpi_timeout.sv
// Saturating cycle counter with synchronous clear; expired is high once the count reaches MaxCount.
module airi5c_pcpi_timeout #(
  parameter int unsigned MaxCount = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MaxCount + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxCount);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/airi5c_pcpi_issue.sv
// EX-stage PCPI initiator: issues to the coprocessor, stalls EX until it answers, strobes the result.
// Define AIRI5C_PCPI_TIMEOUT_EN to add the unclaimed-instruction timeout and illegal_insn_o strobe.
module airi5c_pcpi_issue
  import airi5c_pcpi_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PCPI_TIMEOUT_DEFAULT,
  parameter int unsigned XPR_LEN        = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pcpi_valid_unkilled_ex_i,
  input  logic               kill_ex_i,
  input  logic [31:0]        inst_ex_i,
  input  logic [XPR_LEN-1:0] rs1_ex_i,
  input  logic [XPR_LEN-1:0] rs2_ex_i,
  output logic               pcpi_valid_o,
  output logic [31:0]        pcpi_insn_o,
  output logic [XPR_LEN-1:0] pcpi_rs1_o,
  output logic [XPR_LEN-1:0] pcpi_rs2_o,
  input  logic               pcpi_wait_i,
  input  logic               pcpi_ready_i,
  input  logic               pcpi_wr_i,
  input  logic [XPR_LEN-1:0] pcpi_rd_i,
  output logic               stall_ex_o,
  output logic               result_valid_o,
  output logic               result_wr_o,
  output logic [XPR_LEN-1:0] result_o,
  output logic               illegal_insn_o
);

  pcpi_state_e        state_q, state_d;
  logic               req;
  logic               expired;
  logic               valid_q;
  logic [31:0]        insn_q;
  logic [XPR_LEN-1:0] rs1_q, rs2_q, result_q;
  logic               result_wr_q;

  assign req = pcpi_valid_unkilled_ex_i & ~kill_ex_i;

`ifdef AIRI5C_PCPI_TIMEOUT_EN
  // Counter only runs in ISSUE; a busy coprocessor keeps restarting it.
  airi5c_pcpi_timeout #(
    .MaxCount(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    ((state_q != PCPI_ST_ISSUE) | pcpi_wait_i),
    .en_i     (state_q == PCPI_ST_ISSUE),
    .expired_o(expired)
  );
  assign illegal_insn_o = (state_q == PCPI_ST_ERR);
`else
  logic unused_timeout;
  assign unused_timeout = pcpi_wait_i ^ (TIMEOUT_CYCLES != 0);
  assign expired        = 1'b0;
  assign illegal_insn_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    stall_ex_o = 1'b0;
    unique case (state_q)
      PCPI_ST_IDLE: begin
        if (req) begin
          state_d    = PCPI_ST_ISSUE;
          stall_ex_o = 1'b1;
        end
      end
      PCPI_ST_ISSUE: begin
        stall_ex_o = 1'b1;
        if (kill_ex_i) begin
          state_d = PCPI_ST_IDLE;
        end else if (pcpi_ready_i) begin
          state_d = PCPI_ST_DONE;
        end else if (expired) begin
          state_d = PCPI_ST_ERR;
        end
      end
      PCPI_ST_DONE: state_d = PCPI_ST_IDLE;
      PCPI_ST_ERR:  state_d = PCPI_ST_IDLE;
      default:      state_d = PCPI_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PCPI_ST_IDLE;
      valid_q     <= 1'b0;
      insn_q      <= RV_NOP;
      rs1_q       <= '0;
      rs2_q       <= '0;
      result_q    <= '0;
      result_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == PCPI_ST_ISSUE);
      if ((state_q == PCPI_ST_IDLE) && req) begin
        insn_q <= inst_ex_i;
        rs1_q  <= rs1_ex_i;
        rs2_q  <= rs2_ex_i;
      end
      if ((state_q == PCPI_ST_ISSUE) && !kill_ex_i && pcpi_ready_i) begin
        result_q    <= pcpi_rd_i;
        result_wr_q <= pcpi_wr_i;
      end
    end
  end

  assign pcpi_valid_o   = valid_q;
  assign pcpi_insn_o    = insn_q;
  assign pcpi_rs1_o     = rs1_q;
  assign pcpi_rs2_o     = rs2_q;
  assign result_valid_o = (state_q == PCPI_ST_DONE);
  assign result_wr_o    = result_wr_q;
  assign result_o       = result_q;

endmodule

// File: tb/tb_airi5c_pcpi_issue.sv
// Bench for airi5c_pcpi_issue: directed vector table, hand sequences and randomized model comparison.
module tb_airi5c_pcpi_issue;

  localparam int unsigned T  = 16;
  localparam int unsigned XL = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst, q_in, kill, wt, rdy, wr_in;
  logic [31:0] insn_in, rs1_in, rs2_in, rd_in;
  logic pcpi_valid, stall, rv, res_wr, ill;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, res;

  always #5 clk = ~clk;

  airi5c_pcpi_issue #(
    .TIMEOUT_CYCLES(T),
    .XPR_LEN       (XL)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .pcpi_valid_unkilled_ex_i(q_in),
    .kill_ex_i               (kill),
    .inst_ex_i               (insn_in),
    .rs1_ex_i                (rs1_in),
    .rs2_ex_i                (rs2_in),
    .pcpi_valid_o            (pcpi_valid),
    .pcpi_insn_o             (pcpi_insn),
    .pcpi_rs1_o              (pcpi_rs1),
    .pcpi_rs2_o              (pcpi_rs2),
    .pcpi_wait_i             (wt),
    .pcpi_ready_i            (rdy),
    .pcpi_wr_i               (wr_in),
    .pcpi_rd_i               (rd_in),
    .stall_ex_o              (stall),
    .result_valid_o          (rv),
    .result_wr_o             (res_wr),
    .result_o                (res),
    .illegal_insn_o          (ill)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: busy = coprocessor owns the instruction; done/err = one-cycle strobes pending.
  bit m_busy, m_done, m_err, m_wr;
  int m_cnt;
  logic [31:0] m_insn, m_rs1, m_rs2, m_res;

  logic o_stall, o_valid, o_rv, o_ill, o_wr;
  logic [31:0] o_insn, o_rs1, o_res;

  typedef struct {
    bit q, k, w, r, wrb;
    logic [31:0] rd, insn, a, b;
    bit e_stall, e_valid, e_rv, e_wr;
    logic [31:0] e_res;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_wr = 0; m_cnt = 0;
    m_insn = NOP; m_rs1 = 0; m_rs2 = 0; m_res = 0;
  endtask

  task automatic step(input bit r, input bit q, input bit k, input bit w, input bit ry,
                      input bit wrb, input logic [31:0] rdv, input logic [31:0] iv,
                      input logic [31:0] a, input logic [31:0] b);
    bit e_stall;
    rst = r; q_in = q; kill = k; wt = w; rdy = ry; wr_in = wrb; rd_in = rdv;
    insn_in = iv; rs1_in = a; rs2_in = b;
    @(negedge clk);
    e_stall = m_busy || (!m_done && !m_err && q && !k);
    chk("m_stall", stall, e_stall);
    chk("m_valid", pcpi_valid, m_busy);
    chk("m_rv", rv, m_done);
    chk("m_ill", ill, m_err);
    chk("m_insn", pcpi_insn, m_insn);
    chk("m_rs1", pcpi_rs1, m_rs1);
    chk("m_rs2", pcpi_rs2, m_rs2);
    chk("m_res", res, m_res);
    chk("m_wr", res_wr, m_wr);
    o_stall = stall; o_valid = pcpi_valid; o_rv = rv; o_ill = ill; o_wr = res_wr;
    o_insn = pcpi_insn; o_rs1 = pcpi_rs1; o_res = res;
    @(posedge clk);
    if (r) model_reset();
    else if (m_done || m_err) begin
      m_done = 0; m_err = 0;
    end else if (!m_busy) begin
      if (q && !k) begin
        m_insn = iv; m_rs1 = a; m_rs2 = b; m_cnt = 0; m_busy = 1;
      end
    end else if (k) m_busy = 0;
    else if (ry) begin
      m_res = rdv; m_wr = wrb; m_busy = 0; m_done = 1;
    end
`ifdef AIRI5C_PCPI_TIMEOUT_EN
    else if (m_cnt == T) begin
      m_busy = 0; m_err = 1;
    end
`endif
    else m_cnt = w ? 0 : ((m_cnt < T) ? m_cnt + 1 : T);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rv, n_ill, first_ill;
    bit v17, v18;
    bit mode;
    tbl[0]  = '{1, 0, 0, 0, 0, 0,   32'h0200_00B3, 5, 7, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 35,  0,             0, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0,   0,             0, 0, 0, 0, 1, 1, 35};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,   0,             0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0,   32'h02B5_0533, 1, 2, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 100, 0,             0, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0,   32'h02B5_0533, 1, 2, 0, 0, 1, 1, 100};
    tbl[7]  = '{1, 0, 0, 0, 0, 0,   32'h02C6_85B3, 3, 4, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 200, 0,             0, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,   0,             0, 0, 0, 0, 1, 0, 200};
    tbl[10] = '{0, 0, 0, 0, 0, 0,   0,             0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 0,   32'h02D7_0633, 6, 8, 1, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 1, 1, 55,  32'h02D7_0633, 6, 8, 1, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0,   0,             0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0,   0,             0, 0, 0, 0, 0, 0, 0};

    rst = 1; q_in = 0; kill = 0; wt = 0; rdy = 0; wr_in = 0;
    rd_in = 0; insn_in = 0; rs1_in = 0; rs2_in = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    idle();
    chk("rst_insn", o_insn, NOP);
    chk("rst_stall", o_stall, 0);
    chk("rst_valid", o_valid, 0);

    // Single-cycle, back-to-back and kill-race vectors
    for (int i = 0; i < 15; i++) begin
      step(0, tbl[i].q, tbl[i].k, tbl[i].w, tbl[i].r, tbl[i].wrb, tbl[i].rd, tbl[i].insn,
           tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_stall", i), o_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_rv", i), o_rv, tbl[i].e_rv);
      chk($sformatf("tbl%0d_ill", i), o_ill, 0);
      if (tbl[i].e_rv) begin
        chk($sformatf("tbl%0d_res", i), o_res, tbl[i].e_res);
        chk($sformatf("tbl%0d_wr", i), o_wr, tbl[i].e_wr);
      end
    end

    // Slow coprocessor: busy for 40 cycles, then ready
    n_rv = 0; n_ill = 0;
    step(0, 1, 0, 0, 0, 0, 0, 32'h0200_8133, 11, 12);
    for (int c = 0; c < 40; c++) begin
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      n_rv += int'(o_rv); n_ill += int'(o_ill);
    end
    step(0, 0, 0, 0, 1, 1, 32'h0000_1234, 0, 0, 0);
    n_rv += int'(o_rv); n_ill += int'(o_ill);
    for (int c = 0; c < 3; c++) begin
      idle();
      n_rv += int'(o_rv); n_ill += int'(o_ill);
      if (c == 0) chk("slow_res", o_res, 32'h0000_1234);
    end
    chk("slow_rv_count", n_rv, 1);
    chk("slow_ill_count", n_ill, 0);

    // Unclaimed instruction
    n_ill = 0; first_ill = -1; v17 = 0; v18 = 0;
    step(0, 1, 0, 0, 0, 0, 0, 32'h0201_01B3, 1, 1);
    for (int c = 1; c <= 30; c++) begin
      idle();
      if (o_ill) begin
        n_ill++;
        if (first_ill < 0) first_ill = c;
      end
      if (c == 17) v17 = o_valid;
      if (c == 18) v18 = o_valid;
    end
`ifdef AIRI5C_PCPI_TIMEOUT_EN
    chk("unclaimed_ill_cycle", first_ill, 18);
    chk("unclaimed_ill_count", n_ill, 1);
    chk("unclaimed_valid17", v17, 1);
    chk("unclaimed_valid18", v18, 0);
`else
    chk("unclaimed_ill_count", n_ill, 0);
    chk("unclaimed_valid_held", o_valid, 1);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("unclaimed_kill_valid", o_valid, 0);
`endif

    // Reset mid-transaction
    n_rv = 0; n_ill = 0;
    step(0, 1, 0, 0, 0, 0, 0, 32'h02E7_86B3, 9, 9);
    step(1, 0, 0, 0, 1, 1, 77, 0, 0, 0);
    idle();
    chk("midrst_valid", o_valid, 0);
    chk("midrst_stall", o_stall, 0);
    chk("midrst_insn", o_insn, NOP);
    chk("midrst_rs1", o_rs1, 0);
    chk("midrst_res", o_res, 0);
    n_rv += int'(o_rv); n_ill += int'(o_ill);
    for (int c = 0; c < 3; c++) begin
      idle();
      n_rv += int'(o_rv); n_ill += int'(o_ill);
    end
    chk("midrst_no_strobe", n_rv + n_ill, 0);

    // Randomized traffic against the model
    mode = 0;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) mode = ~mode;
      if (mode)
        step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
             $urandom, $urandom, $urandom, $urandom);
      else
        step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 49) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
             $urandom, $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
